// File: rtl/line_window_buffer.sv
// Streaming KERNEL_HEIGHT x KERNEL_WIDTH sliding-window generator for raster-order pixels.
// Buffers KERNEL_HEIGHT-1 lines and emits strided windows with valid/ready on both sides.
module line_window_buffer #(
    parameter int DATA_RES      = 8,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int LINE_WIDTH    = 28,
    parameter int IMG_HEIGHT    = 28,
    parameter int STRIDE        = 1
) (
    input  logic                                           clk_i,
    input  logic                                           reset_i,
    input  logic [DATA_RES-1:0]                            pixel_i,
    input  logic                                           pixel_valid_i,
    output logic                                           pixel_ready_o,
    output logic [KERNEL_HEIGHT*KERNEL_WIDTH*DATA_RES-1:0] win_data_o,
    output logic                                           win_valid_o,
    input  logic                                           win_ready_i,
    output logic [$clog2(IMG_HEIGHT)-1:0]                  win_row_o,
    output logic [$clog2(LINE_WIDTH)-1:0]                  win_col_o,
    output logic                                           frame_done_o
);
    localparam int CW = $clog2(LINE_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int NL = (KERNEL_HEIGHT > 1) ? KERNEL_HEIGHT - 1 : 1;
    localparam int WW = KERNEL_HEIGHT * KERNEL_WIDTH * DATA_RES;

    localparam logic [CW-1:0] COL_LAST      = CW'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERNEL_HEIGHT - 1);
    localparam logic [SW-1:0] PHASE_LAST    = SW'(STRIDE - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [SW-1:0]       r_colPhase;
    logic [SW-1:0]       r_rowPhase;
    logic                r_winValid;
    logic [WW-1:0]       r_winData;
    logic [RW-1:0]       r_winRow;
    logic [CW-1:0]       r_winCol;
    logic                r_frameDone;
    logic [DATA_RES-1:0] r_win     [KERNEL_HEIGHT][KERNEL_WIDTH];

    logic [DATA_RES-1:0] w_lineOut [NL];
    logic [DATA_RES-1:0] w_newCol  [KERNEL_HEIGHT];
    logic [DATA_RES-1:0] w_winNext [KERNEL_HEIGHT][KERNEL_WIDTH];
    logic [WW-1:0]       w_winFlat;

    logic w_accept;
    logic w_lastCol;
    logic w_lastRow;
    logic w_frameEnd;
    logic w_colOk;
    logic w_rowOk;
    logic w_fillDone;
    logic w_emit;

    assign pixel_ready_o = !r_winValid || win_ready_i;
    assign w_accept      = pixel_valid_i && pixel_ready_o;
    assign w_lastCol     = (r_col == COL_LAST);
    assign w_lastRow     = (r_row == ROW_LAST);
    assign w_frameEnd    = w_lastCol && w_lastRow;
    assign w_fillDone    = (r_row == ROW_FIRST_WIN) && (r_col == COL_FIRST_WIN);
    // A zero phase marks a column/row that lies on the stride grid of the window origin.
    assign w_colOk       = (r_col >= COL_FIRST_WIN) && (r_colPhase == '0);
    assign w_rowOk       = (r_row >= ROW_FIRST_WIN) && (r_rowPhase == '0);
    assign w_emit        = w_accept && w_colOk && w_rowOk && ((r_state == RUN) || w_fillDone);

    assign win_valid_o  = r_winValid;
    assign win_data_o   = r_winData;
    assign win_row_o    = r_winRow;
    assign win_col_o    = r_winCol;
    assign frame_done_o = r_frameDone;

    generate
        if (KERNEL_HEIGHT > 1) begin : g_lines
            logic [DATA_RES-1:0] r_lines [NL][LINE_WIDTH];

            // Index 0 holds the oldest line; each accept pushes the column up by one line.
            always_ff @(posedge clk_i) begin
                if (w_accept) begin
                    for (int i = 0; i < NL - 1; i++) begin
                        r_lines[i][r_col] <= r_lines[i+1][r_col];
                    end
                    r_lines[NL-1][r_col] <= pixel_i;
                end
            end

            always_comb begin
                for (int i = 0; i < NL; i++) begin
                    w_lineOut[i] = r_lines[i][r_col];
                end
            end
        end else begin : g_noLines
            always_comb w_lineOut[0] = '0;
        end
    endgenerate

    always_comb begin
        w_winFlat = '0;
        for (int i = 0; i < KERNEL_HEIGHT - 1; i++) begin
            w_newCol[i] = w_lineOut[i];
        end
        w_newCol[KERNEL_HEIGHT-1] = pixel_i;
        for (int i = 0; i < KERNEL_HEIGHT; i++) begin
            for (int j = 0; j < KERNEL_WIDTH - 1; j++) begin
                w_winNext[i][j] = r_win[i][j+1];
            end
            w_winNext[i][KERNEL_WIDTH-1] = w_newCol[i];
        end
        for (int i = 0; i < KERNEL_HEIGHT; i++) begin
            for (int j = 0; j < KERNEL_WIDTH; j++) begin
                w_winFlat[((KERNEL_HEIGHT-1-i)*KERNEL_WIDTH + (KERNEL_WIDTH-1-j))*DATA_RES +: DATA_RES] = w_winNext[i][j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_win <= w_winNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            FILL: if (w_accept && w_fillDone && !w_frameEnd) w_stateNext = RUN;
            RUN:  if (w_accept && w_frameEnd) w_stateNext = FILL;
            default: w_stateNext = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= FILL;
            r_col       <= '0;
            r_row       <= '0;
            r_colPhase  <= '0;
            r_rowPhase  <= '0;
            r_winValid  <= 1'b0;
            r_winData   <= '0;
            r_winRow    <= '0;
            r_winCol    <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_frameDone <= w_accept && w_frameEnd;
            if (w_accept) begin
                if (w_lastCol) begin
                    r_col      <= '0;
                    r_colPhase <= '0;
                    if (w_lastRow) begin
                        r_row      <= '0;
                        r_rowPhase <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                        if (r_row >= ROW_FIRST_WIN) begin
                            r_rowPhase <= (r_rowPhase == PHASE_LAST) ? '0 : r_rowPhase + SW'(1);
                        end
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                    if (r_col >= COL_FIRST_WIN) begin
                        r_colPhase <= (r_colPhase == PHASE_LAST) ? '0 : r_colPhase + SW'(1);
                    end
                end
            end
            // A fresh window may replace the one being handed off in the same cycle.
            if (w_emit) begin
                r_winValid <= 1'b1;
                r_winData  <= w_winFlat;
                r_winRow   <= r_row - ROW_FIRST_WIN;
                r_winCol   <= r_col - COL_FIRST_WIN;
            end else if (win_ready_i) begin
                r_winValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: three 3x3 instances (4x4, 5x5 stride 2, 28x28)
// driven one at a time and scored against windows computed directly from the frame contents.
module tb_line_window_buffer;
    typedef struct packed {
        logic [1:0]  inst;
        logic [71:0] data;
        logic [4:0]  row;
        logic [4:0]  col;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, pv, pr, wv, wr, fd;
    logic [2:0][7:0]  pix;
    logic [2:0][71:0] wd;
    logic [2:0][4:0]  wrow, wcol;
    logic [1:0]       row0, col0;
    logic [2:0]       row1, col1;
    logic [4:0]       row2, col2;

    assign wrow[0] = {3'b000, row0};
    assign wcol[0] = {3'b000, col0};
    assign wrow[1] = {2'b00, row1};
    assign wcol[1] = {2'b00, col1};
    assign wrow[2] = row2;
    assign wcol[2] = col2;

    int checks = 0;
    int errors = 0;
    int winCount[3] = '{0, 0, 0};
    int expCount[3] = '{0, 0, 0};
    int fdCount[3]  = '{0, 0, 0};
    int fdExp[3]    = '{0, 0, 0};
    int cfgLw[3]    = '{4, 5, 28};
    int cfgIh[3]    = '{4, 5, 28};
    int cfgSt[3]    = '{1, 2, 1};

    win_t        expQ[$];
    win_t        monE;
    logic [7:0]  frame[784];
    logic [2:0]  stalled = '0;
    logic [71:0] holdData[3];
    logic [4:0]  holdRow[3];
    logic [4:0]  holdCol[3];

    line_window_buffer #(.DATA_RES(8), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
                         .LINE_WIDTH(4), .IMG_HEIGHT(4), .STRIDE(1)) u0 (
        .clk_i(clk), .reset_i(rst[0]), .pixel_i(pix[0]), .pixel_valid_i(pv[0]),
        .pixel_ready_o(pr[0]), .win_data_o(wd[0]), .win_valid_o(wv[0]), .win_ready_i(wr[0]),
        .win_row_o(row0), .win_col_o(col0), .frame_done_o(fd[0]));

    line_window_buffer #(.DATA_RES(8), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
                         .LINE_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2)) u1 (
        .clk_i(clk), .reset_i(rst[1]), .pixel_i(pix[1]), .pixel_valid_i(pv[1]),
        .pixel_ready_o(pr[1]), .win_data_o(wd[1]), .win_valid_o(wv[1]), .win_ready_i(wr[1]),
        .win_row_o(row1), .win_col_o(col1), .frame_done_o(fd[1]));

    line_window_buffer #(.DATA_RES(8), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
                         .LINE_WIDTH(28), .IMG_HEIGHT(28), .STRIDE(1)) u2 (
        .clk_i(clk), .reset_i(rst[2]), .pixel_i(pix[2]), .pixel_valid_i(pv[2]),
        .pixel_ready_o(pr[2]), .win_data_o(wd[2]), .win_valid_o(wv[2]), .win_ready_i(wr[2]),
        .win_row_o(row2), .win_col_o(col2), .frame_done_o(fd[2]));

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fillFrame(input int base, input bit rnd);
        for (int i = 0; i < 784; i++) begin
            frame[i] = rnd ? 8'($urandom) : 8'(base + i);
        end
    endtask

    // Reference: every grid-aligned 3x3 window of the frame, row-major, top-left in the MSB byte.
    task automatic pushModel(input int u);
        win_t e;
        for (int r = 0; r <= cfgIh[u] - 3; r += cfgSt[u]) begin
            for (int c = 0; c <= cfgLw[u] - 3; c += cfgSt[u]) begin
                e.inst = 2'(u);
                e.row  = 5'(r);
                e.col  = 5'(c);
                e.data = '0;
                for (int k = 0; k < 9; k++) begin
                    e.data = {e.data[63:0], frame[(r + k / 3) * cfgLw[u] + c + k % 3]};
                end
                expQ.push_back(e);
                expCount[u]++;
            end
        end
        fdExp[u]++;
    endtask

    task automatic applyStimulus(input int u, input int n, input int vPct, input int rPct, input int stallLen);
        int  idx = 0;
        int  cycles = 0;
        int  stallLeft = stallLen;
        bit  acc;
        while (idx < n && cycles < 20000) begin
            pix[u] = frame[idx];
            pv[u]  = ($urandom_range(99) < vPct);
            if (stallLeft > 0 && wv[u]) begin
                wr[u] = 1'b0;
                stallLeft--;
            end else begin
                wr[u] = ($urandom_range(99) < rPct);
            end
            @(negedge clk);
            acc = pv[u] && pr[u];
            @(posedge clk);
            #1;
            if (acc) idx++;
            cycles++;
        end
        pv[u] = 1'b0;
        checkOutput("pixels_sent", 72'(idx), 72'(n));
    endtask

    task automatic drain(input int u);
        pv[u] = 1'b0;
        wr[u] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("window_count", 72'(winCount[u]), 72'(expCount[u]));
        checkOutput("frame_done_count", 72'(fdCount[u]), 72'(fdExp[u]));
        checkOutput("queue_empty", 72'(expQ.size()), 72'(0));
    endtask

    task automatic resetPulse(input int u);
        rst[u] = 1'b1;
        @(posedge clk);
        #1;
        rst[u] = 1'b0;
    endtask

    // Scoreboard and stall-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rst[u]) begin
                stalled[u] = 1'b0;
            end else begin
                if (stalled[u]) begin
                    checkOutput("stall_valid", 72'(wv[u]), 72'(1));
                    checkOutput("stall_data", wd[u], holdData[u]);
                    checkOutput("stall_row", 72'(wrow[u]), 72'(holdRow[u]));
                    checkOutput("stall_col", 72'(wcol[u]), 72'(holdCol[u]));
                end
                if (wv[u]) checkOutput("pixel_ready", 72'(pr[u]), 72'(wr[u]));
                if (wv[u] && wr[u]) begin
                    checkOutput("window_expected", 72'(expQ.size() > 0), 72'(1));
                    if (expQ.size() > 0) begin
                        monE = expQ.pop_front();
                        checkOutput("window_inst", 72'(u), 72'(monE.inst));
                        checkOutput("window_data", wd[u], monE.data);
                        checkOutput("window_row", 72'(wrow[u]), 72'(monE.row));
                        checkOutput("window_col", 72'(wcol[u]), 72'(monE.col));
                    end
                    winCount[u]++;
                end
                if (fd[u]) begin
                    fdCount[u]++;
                    checkOutput("done_with_window", 72'(wv[u]), 72'(1));
                end
                stalled[u]  = wv[u] && !wr[u];
                holdData[u] = wd[u];
                holdRow[u]  = wrow[u];
                holdCol[u]  = wcol[u];
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before the sequence completed");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = '1;
        pv  = '0;
        wr  = '1;
        pix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checkOutput("reset_valid", 72'(wv[u]), 72'(0));
            checkOutput("reset_data", wd[u], 72'(0));
            checkOutput("reset_row", 72'(wrow[u]), 72'(0));
            checkOutput("reset_col", 72'(wcol[u]), 72'(0));
            checkOutput("reset_done", 72'(fd[u]), 72'(0));
        end
        @(posedge clk);
        #1;
        rst = '0;

        $display("[TB] 4x4 frame, consumer always ready");
        fillFrame(0, 1'b0);
        pushModel(0);
        applyStimulus(0, 16, 100, 100, 0);
        drain(0);

        $display("[TB] 4x4 frame, consumer stalls five cycles on the first window");
        fillFrame(0, 1'b0);
        pushModel(0);
        applyStimulus(0, 16, 100, 100, 5);
        drain(0);

        $display("[TB] 5x5 frame, stride 2");
        fillFrame(0, 1'b0);
        pushModel(1);
        applyStimulus(1, 25, 100, 100, 0);
        drain(1);

        $display("[TB] two back-to-back 4x4 frames");
        fillFrame(0, 1'b0);
        pushModel(0);
        applyStimulus(0, 16, 100, 100, 0);
        fillFrame(100, 1'b0);
        pushModel(0);
        applyStimulus(0, 16, 100, 100, 0);
        drain(0);

        $display("[TB] reset after ten pixels, then a full frame");
        fillFrame(0, 1'b0);
        applyStimulus(0, 10, 100, 100, 0);
        resetPulse(0);
        checkOutput("midreset_valid", 72'(wv[0]), 72'(0));
        pushModel(0);
        applyStimulus(0, 16, 100, 100, 0);
        drain(0);

        $display("[TB] reset while a window is pending");
        fillFrame(0, 1'b0);
        applyStimulus(0, 11, 100, 0, 0);
        checkOutput("pending_valid", 72'(wv[0]), 72'(1));
        resetPulse(0);
        checkOutput("pending_cleared", 72'(wv[0]), 72'(0));
        checkOutput("pending_data", wd[0], 72'(0));
        fillFrame(0, 1'b1);
        pushModel(0);
        applyStimulus(0, 16, 70, 70, 0);
        drain(0);

        $display("[TB] random gaps on 4x4 and 5x5 stride 2");
        for (int f = 0; f < 2; f++) begin
            fillFrame(0, 1'b1);
            pushModel(0);
            applyStimulus(0, 16, 50, 50, 0);
        end
        drain(0);
        for (int f = 0; f < 2; f++) begin
            fillFrame(0, 1'b1);
            pushModel(1);
            applyStimulus(1, 25, 50, 50, 0);
        end
        drain(1);

        $display("[TB] 28x28 random frame with random gaps");
        fillFrame(0, 1'b1);
        pushModel(2);
        applyStimulus(2, 784, 50, 50, 0);
        drain(2);
        checkOutput("default_window_total", 72'(winCount[2]), 72'(676));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
